// File: rtl/sass_note_pkg.sv
// Shared note codes, the 16-bit phase increment table and FSM state type
// for the note tone generator slice.
package sass_note_pkg;

  localparam logic [3:0] NOTE_OFF    = 4'd0;
  localparam logic [3:0] NOTE_LOW_C  = 4'd1;
  localparam logic [3:0] NOTE_CS     = 4'd2;
  localparam logic [3:0] NOTE_D      = 4'd3;
  localparam logic [3:0] NOTE_DS     = 4'd4;
  localparam logic [3:0] NOTE_E      = 4'd5;
  localparam logic [3:0] NOTE_F      = 4'd6;
  localparam logic [3:0] NOTE_FS     = 4'd7;
  localparam logic [3:0] NOTE_G      = 4'd8;
  localparam logic [3:0] NOTE_GS     = 4'd9;
  localparam logic [3:0] NOTE_A      = 4'd10;
  localparam logic [3:0] NOTE_AS     = 4'd11;
  localparam logic [3:0] NOTE_B      = 4'd12;
  localparam logic [3:0] NOTE_HIGH_C = 4'd13;
  localparam logic [3:0] NOTE_MAX    = NOTE_HIGH_C;

  // round(f * 65536 / 10000) for lowC..highC; entry i belongs to note code i+1
  localparam logic [15:0] INC_TABLE [13] = '{
    16'd1715, 16'd1817, 16'd1925, 16'd2039, 16'd2160, 16'd2289, 16'd2425,
    16'd2569, 16'd2722, 16'd2884, 16'd3055, 16'd3237, 16'd3429
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } note_state_e;

  function automatic logic note_is_valid(input logic [3:0] note);
    return (note != NOTE_OFF) && (note <= NOTE_MAX);
  endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Note bus into the tone generator plus its audio and debug outputs.
// Optional octave_up input exists only when SASS_OCTAVE_UP_EN is defined.
interface note_tone_gen_if #(parameter int ACC_W = 16);
  import sass_note_pkg::*;

  // Level-based bus, no valid/ready: the note code is a level sampled on
  // every clk edge and the generator is always ready, so nothing is stalled.
  logic             en;
  logic [3:0]       note_in;
`ifdef SASS_OCTAVE_UP_EN
  logic             octave_up;
`endif
  logic             tone_out;
  logic             active;
  logic [3:0]       cur_note;
  note_state_e      dbg_state;
  logic [ACC_W-1:0] dbg_acc;

  modport master (
`ifdef SASS_OCTAVE_UP_EN
    output octave_up,
`endif
    output en, note_in,
    input  tone_out, active, cur_note, dbg_state, dbg_acc
  );

  modport slave (
`ifdef SASS_OCTAVE_UP_EN
    input  octave_up,
`endif
    input  en, note_in,
    output tone_out, active, cur_note, dbg_state, dbg_acc
  );

endinterface

// File: rtl/note_inc_lut.sv
// Note code to phase increment, scaled to the accumulator width.
// Codes 0, 14 and 15 give a zero increment.
module note_inc_lut
  import sass_note_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [3:0]       note,
  output logic [ACC_W-1:0] inc
);

  logic [15:0] base;

  always_comb begin
    base = '0;
    for (int i = 0; i < int'(NOTE_MAX); i++) begin
      if (note == 4'(i + 1)) base = INC_TABLE[i];
    end
    inc = ACC_W'(base) << (ACC_W - 16);
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: IDLE/PLAY/RELEASE FSM, phase accumulator and
// release tail counter. Macro SASS_OCTAVE_UP_EN adds the octave_up input.
module note_tone_gen
  import sass_note_pkg::*;
#(
  parameter int ACC_W          = 16,
  parameter int RELEASE_CYCLES = 500
) (
  input logic              clk,
  input logic              n_rst,
  note_tone_gen_if.slave   bus
);

  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [REL_W-1:0] REL_INIT =
    (RELEASE_CYCLES > 0) ? REL_W'(RELEASE_CYCLES - 1) : '0;

  note_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       note_q, note_d;
  logic [REL_W-1:0] rel_q, rel_d;

  logic [ACC_W-1:0] inc, inc_eff;
  logic             note_valid;

  note_inc_lut #(.ACC_W(ACC_W)) u_lut (
    .note (note_q),
    .inc  (inc)
  );

`ifdef SASS_OCTAVE_UP_EN
  assign inc_eff = bus.octave_up ? (inc << 1) : inc;
`else
  assign inc_eff = inc;
`endif

  assign note_valid = note_is_valid(bus.note_in);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      note_q  <= NOTE_OFF;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      note_q  <= note_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    note_d  = note_q;
    rel_d   = rel_q;
    if (!bus.en) begin
      state_d = IDLE;
      acc_d   = '0;
      note_d  = NOTE_OFF;
      rel_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          acc_d = '0;
          if (note_valid) begin
            state_d = PLAY;
            note_d  = bus.note_in;
          end
        end
        PLAY: begin
          // Phase continues across note changes so glides are glitch-free
          acc_d = acc_q + inc_eff;
          if (note_valid) begin
            note_d = bus.note_in;
          end else if (RELEASE_CYCLES > 0) begin
            state_d = RELEASE;
            rel_d   = REL_INIT;
          end else begin
            state_d = IDLE;
            acc_d   = '0;
            note_d  = NOTE_OFF;
          end
        end
        RELEASE: begin
          acc_d = acc_q + inc_eff;
          if (note_valid) begin
            state_d = PLAY;
            note_d  = bus.note_in;
          end else if (rel_q == '0) begin
            state_d = IDLE;
            acc_d   = '0;
            note_d  = NOTE_OFF;
          end else begin
            rel_d = rel_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          note_d  = NOTE_OFF;
        end
      endcase
    end
  end

  assign bus.tone_out  = acc_q[ACC_W-1];
  assign bus.active    = (state_q != IDLE);
  assign bus.cur_note  = note_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_acc   = acc_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Randomised and directed bench for note_tone_gen (ACC_W=16, RELEASE_CYCLES=4)
// against a frequency-derived reference model.
module tb_note_tone_gen;
  import sass_note_pkg::*;

  localparam int ACC_W = 16;
  localparam int REL   = 4;

  logic clk;
  logic n_rst;
  note_tone_gen_if #(.ACC_W(ACC_W)) bus ();

  note_tone_gen #(.ACC_W(ACC_W), .RELEASE_CYCLES(REL)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [ACC_W-1:0] exp_q[$];

  // reference model: note pitch from frequency, tail measured in silent edges
  real freq_hz [1:13] = '{261.63, 277.18, 293.66, 311.13, 329.63, 349.23,
                          369.99, 392.00, 415.30, 440.00, 466.16, 493.88, 523.25};
  int  m_inc [0:15];
  bit  m_sounding;
  int  m_quiet;
  int  m_phase;
  int  m_note;
  bit  oct;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_silence();
    m_sounding = 1'b0;
    m_quiet    = 0;
    m_phase    = 0;
    m_note     = 0;
  endtask

  task automatic model_edge(input bit en_v, input int n, input bit oct_v);
    bit held;
    held = (n >= 1) && (n <= 13);
    if (!en_v) begin
      model_silence();
    end else if (!m_sounding) begin
      if (held) begin
        m_sounding = 1'b1;
        m_note     = n;
        m_quiet    = 0;
      end
    end else begin
      m_phase = (m_phase + m_inc[m_note] * (oct_v ? 2 : 1)) % 65536;
      if (held) begin
        m_note  = n;
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet > REL) model_silence();
      end
    end
    exp_q.push_back(ACC_W'(m_phase));
  endtask

  task automatic compare_outputs(input string tag);
    logic [ACC_W-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_acc"},    32'(bus.dbg_acc),  32'(e));
    check({tag, "_tone"},   32'(bus.tone_out), 32'(e[ACC_W-1]));
    check({tag, "_active"}, 32'(bus.active),   32'(m_sounding));
    check({tag, "_note"},   32'(bus.cur_note), 32'(m_note));
  endtask

  // driver tasks
  task automatic drive(input bit en_v, input logic [3:0] n);
    bus.en      = en_v;
    bus.note_in = n;
`ifdef SASS_OCTAVE_UP_EN
    bus.octave_up = oct;
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(bus.en, int'(bus.note_in), oct);
    #1;
    compare_outputs(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    model_silence();
    exp_q.push_back('0);
    compare_outputs("reset");
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_inc[i] = 0;
    for (int i = 1; i <= 13; i++) m_inc[i] = int'($floor(freq_hz[i] * 65536.0 / 10000.0 + 0.5));
    model_silence();
    oct   = 1'b0;
    n_rst = 1'b1;
    drive(1'b0, NOTE_OFF);
    #20;
    do_reset();

    // attack on A: active after first edge, tone rises on the 12th accumulation
    drive(1'b1, NOTE_A);
    tick("attack0");
    check("attack_active", 32'(bus.active), 32'd1);
    ticks(11, "attack");
    check("attack_tone11", 32'(bus.tone_out), 32'd0);
    tick("attack12");
    check("attack_acc12", 32'(bus.dbg_acc), 32'd34608);
    check("attack_tone12", 32'(bus.tone_out), 32'd1);

    // asynchronous reset while playing
    #20;
    do_reset();

    // glide lowC -> highC keeps phase
    drive(1'b1, NOTE_LOW_C);
    ticks(6, "glide_lo");
    drive(1'b1, NOTE_HIGH_C);
    ticks(5, "glide_hi");
    check("glide_cur", 32'(bus.cur_note), 32'd13);

    // release tail then re-trigger during the tail
    drive(1'b1, NOTE_E);
    ticks(3, "rel_play");
    drive(1'b1, NOTE_OFF);
    ticks(4, "rel_tail");
    check("rel_still", 32'(bus.active), 32'd1);
    tick("rel_end");
    check("rel_idle", 32'(bus.active), 32'd0);
    drive(1'b1, NOTE_E);
    ticks(3, "rel2_play");
    drive(1'b1, NOTE_OFF);
    ticks(2, "rel2_tail");
    drive(1'b1, NOTE_G);
    ticks(3, "rel2_back");
    check("rel2_cur", 32'(bus.cur_note), 32'd8);

    // invalid code from idle
    drive(1'b1, NOTE_OFF);
    ticks(6, "drain");
    drive(1'b1, 4'd14);
    ticks(2, "inv14");
    check("inv14_active", 32'(bus.active), 32'd0);

    // wrap: highC for 20 accumulations
    drive(1'b1, NOTE_HIGH_C);
    ticks(21, "wrap");
    check("wrap_acc", 32'(bus.dbg_acc), 32'd3044);

    // en=0 during release
    drive(1'b1, NOTE_OFF);
    ticks(2, "en_rel");
    drive(1'b0, NOTE_OFF);
    tick("en_off");
    check("en_off_active", 32'(bus.active), 32'd0);

`ifdef SASS_OCTAVE_UP_EN
    oct = 1'b1;
    drive(1'b1, NOTE_A);
    ticks(7, "oct");
    check("oct_acc6", 32'(bus.dbg_acc), 32'd34608);
    check("oct_tone6", 32'(bus.tone_out), 32'd1);
    oct = 1'b0;
    drive(1'b0, NOTE_OFF);
    tick("oct_off");
`endif

    // random stimulus with held notes, gaps and occasional mutes
    for (int seg = 0; seg < 120; seg++) begin
      bit          en_r;
      logic [3:0]  n_r;
      en_r = ($urandom_range(0, 14) != 0);
      n_r  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
`ifdef SASS_OCTAVE_UP_EN
      oct = 1'($urandom_range(0, 1));
`endif
      drive(en_r, n_r);
      ticks($urandom_range(1, 8), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
